// File: rtl/data_stat_histogram.sv
`default_nettype none
// ============================================================================
// Module      : data_stat_histogram
// Description : Streaming histogram. Counts occurrences of each DSIZE-bit
//               sample value into 2**DSIZE bins of CSIZE bits. A start pulse
//               clears every bin in one cycle and opens a counting window.
//               A finish pulse closes the window. Bins are read back one per
//               cycle through an index/summary port with 2-cycle latency.
//
// Optional    : DATA_STATISTICS_SAT_EN  - when defined, bins saturate at
//               2**CSIZE-1. When not defined, bins wrap modulo 2**CSIZE.
//
// Ports       : clock        - single clock, rising edge
//               rst          - synchronous active-high reset
//               start        - level, clear all bins and enter COUNT
//               finish       - level, close the counting window
//               data  [D]    - sample value (bin address)
//               vld          - data qualifier
//               get_summary  - read enable for index
//               index [D]    - bin to read
//               summary [C]  - bin[index] of the read issued 2 cycles earlier
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_stat_histogram #(
    parameter int DSIZE = 10,
    parameter int CSIZE = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic [DSIZE-1:0] data,
    input  logic             vld,
    input  logic             get_summary,
    input  logic [DSIZE-1:0] index,
    output logic [CSIZE-1:0] summary
);

    localparam int         c_BINS  = 2 ** DSIZE;
    localparam logic [CSIZE-1:0] c_ONE = {{(CSIZE-1){1'b0}}, 1'b1};
    localparam logic [CSIZE-1:0] c_MAX = {CSIZE{1'b1}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    // Bin storage plus one valid bit per bin. A cleared valid bit makes the
    // bin read as zero, so start clears everything in a single cycle without
    // touching the RAM contents.
    logic [CSIZE-1:0]  r_mem [c_BINS];
    logic [c_BINS-1:0] r_valid;

    // Increment pipeline: s1 holds the accepted sample, s2 holds the new
    // count waiting to be written.
    logic              w_accept;
    logic              r_s1_vld;
    logic [DSIZE-1:0]  r_s1_addr;
    logic              r_s2_vld;
    logic [DSIZE-1:0]  r_s2_addr;
    logic [CSIZE-1:0]  r_s2_cnt;
    logic [CSIZE-1:0]  w_base;
    logic [CSIZE-1:0]  w_next_cnt;

    // Read pipeline.
    logic              r_rd_en;
    logic [DSIZE-1:0]  r_rd_idx;
    logic [CSIZE-1:0]  w_rd_val;
    logic [CSIZE-1:0]  r_summary;

    // ------------------------------------------------------------------
    // Window state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // start has priority over finish in the same cycle.
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = c_COUNT;
        end else if (finish && (r_state == c_COUNT)) begin
            w_state_next = c_DONE;
        end
    end

    // A sample that arrives together with finish is still inside the window.
    assign w_accept = vld && !start && (r_state == c_COUNT);

    // ------------------------------------------------------------------
    // Increment pipeline
    // ------------------------------------------------------------------
    // Only s2 can hold an unwritten count for the same bin; a sample two
    // cycles older has already reached the RAM, so one forward path covers
    // both back-to-back and every-other-cycle repeats.
    always_comb begin
        w_base = r_valid[r_s1_addr] ? r_mem[r_s1_addr] : '0;
        if (r_s2_vld && (r_s2_addr == r_s1_addr)) begin
            w_base = r_s2_cnt;
        end
    end

    always_comb begin
`ifdef DATA_STATISTICS_SAT_EN
        w_next_cnt = (w_base == c_MAX) ? c_MAX : (w_base + c_ONE);
`else
        w_next_cnt = w_base + c_ONE;
`endif
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_cnt  <= '0;
        end else begin
            r_s1_vld  <= w_accept;
            r_s1_addr <= data;
            // start discards anything still in flight from the old window.
            r_s2_vld  <= r_s1_vld && !start;
            r_s2_addr <= r_s1_addr;
            r_s2_cnt  <= w_next_cnt;
        end
    end

    // RAM contents need no reset: the valid vector masks stale data.
    always_ff @(posedge clock) begin
        if (r_s2_vld) begin
            r_mem[r_s2_addr] <= r_s2_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (rst || start) begin
            r_valid <= '0;
        end else if (r_s2_vld) begin
            r_valid[r_s2_addr] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read port: index captured at t, bin looked up at t+1, summary at t+2
    // ------------------------------------------------------------------
    assign w_rd_val = r_valid[r_rd_idx] ? r_mem[r_rd_idx] : '0;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_rd_en   <= 1'b0;
            r_rd_idx  <= '0;
            r_summary <= '0;
        end else begin
            r_rd_en   <= get_summary;
            r_rd_idx  <= index;
            r_summary <= r_rd_en ? w_rd_val : '0;
        end
    end

    assign summary = r_summary;

endmodule
`default_nettype wire

// File: tb/tb_data_stat_histogram.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_stat_histogram
// Description : Directed self-checking bench for data_stat_histogram. A full
//               size instance covers counting, forwarding, window edges,
//               clear, reset and read latency; a small CSIZE=4 instance
//               covers counter overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_stat_histogram;

    logic        clock = 1'b0;
    logic        rst;
    logic        start, finish, vld, get_summary;
    logic [9:0]  data, index;
    logic [31:0] summary;

    logic        s_start, s_finish, s_vld, s_get_summary;
    logic [1:0]  s_data, s_index;
    logic [3:0]  s_summary;

    int n_checks = 0;
    int n_pass   = 0;
    int model [20];

    always #5 clock = ~clock;

    data_stat_histogram #(.DSIZE(10), .CSIZE(32)) dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .finish      (finish),
        .data        (data),
        .vld         (vld),
        .get_summary (get_summary),
        .index       (index),
        .summary     (summary)
    );

    data_stat_histogram #(.DSIZE(2), .CSIZE(4)) dut_small (
        .clock       (clock),
        .rst         (rst),
        .start       (s_start),
        .finish      (s_finish),
        .data        (s_data),
        .vld         (s_vld),
        .get_summary (s_get_summary),
        .index       (s_index),
        .summary     (s_summary)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic read_main(input logic [9:0] idx, output logic [31:0] val);
        @(negedge clock); get_summary = 1'b1; index = idx;
        @(negedge clock); get_summary = 1'b0;
        @(negedge clock); val = summary;
    endtask

    task automatic read_small(input logic [1:0] idx, output logic [3:0] val);
        @(negedge clock); s_get_summary = 1'b1; s_index = idx;
        @(negedge clock); s_get_summary = 1'b0;
        @(negedge clock); val = s_summary;
    endtask

    task automatic open_window(input int n);
        repeat (n) begin @(negedge clock); start = 1'b1; end
        @(negedge clock); start = 1'b0;
    endtask

    task automatic close_window(input int n);
        repeat (n) begin @(negedge clock); vld = 1'b0; finish = 1'b1; end
        @(negedge clock); finish = 1'b0;
    endtask

    task automatic send(input logic [9:0] d);
        @(negedge clock); vld = 1'b1; data = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] v;
        n_checks++;
        if (summary !== 32'd0) $display("FAIL reset_summary got=%0d exp=0", summary);
        else n_pass++;
        n_checks++;
        if (s_summary !== 4'd0) $display("FAIL reset_small_summary got=%0d exp=0", s_summary);
        else n_pass++;
        read_main(10'd0, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL reset_bin0 got=%0d exp=0", v);
        else n_pass++;
        read_main(10'd1023, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL reset_bin1023 got=%0d exp=0", v);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] v;
        int sum, nonzero;
        int d;
        for (int i = 0; i < 20; i++) model[i] = 0;
        open_window(3);
        for (int i = 0; i < 1000; i++) begin
            d = int'($urandom_range(19, 0));
            model[d]++;
            send(10'(d));
        end
        close_window(30);
        sum = 0;
        for (int i = 0; i < 20; i++) begin
            read_main(10'(i), v);
            sum += int'(v);
            n_checks++;
            if (v !== 32'(model[i])) $display("FAIL random_bin%0d got=%0d exp=%0d", i, v, model[i]);
            else n_pass++;
        end
        n_checks++;
        if (sum != 1000) $display("FAIL random_sum got=%0d exp=1000", sum);
        else n_pass++;
        nonzero = 0;
        for (int i = 20; i < 1024; i++) begin
            read_main(10'(i), v);
            if (v != 0) nonzero++;
        end
        n_checks++;
        if (nonzero != 0) $display("FAIL random_upper_bins nonzero_count=%0d exp=0", nonzero);
        else n_pass++;
    endtask

    task automatic test_read_latency();
        @(negedge clock); get_summary = 1'b1; index = 10'd3;
        @(negedge clock); get_summary = 1'b0;
        n_checks++;
        if (summary !== 32'd0) $display("FAIL latency_t1 got=%0d exp=0", summary);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (summary !== 32'(model[3])) $display("FAIL latency_t2 got=%0d exp=%0d", summary, model[3]);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (summary !== 32'd0) $display("FAIL latency_noread got=%0d exp=0", summary);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        open_window(1);
        repeat (1000) send(10'd1);
        close_window(5);
        read_main(10'd1, v);
        n_checks++;
        if (v !== 32'd1000) $display("FAIL b2b_bin1 got=%0d exp=1000", v);
        else n_pass++;
        read_main(10'd0, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL b2b_bin0 got=%0d exp=0", v);
        else n_pass++;
        read_main(10'd2, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL b2b_bin2 got=%0d exp=0", v);
        else n_pass++;
        read_main(10'd3, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL b2b_bin3_cleared got=%0d exp=0", v);
        else n_pass++;
    endtask

    task automatic test_alternating();
        logic [31:0] v;
        open_window(1);
        repeat (250) begin
            send(10'd5); send(10'd5); send(10'd7); send(10'd5);
        end
        close_window(5);
        read_main(10'd5, v);
        n_checks++;
        if (v !== 32'd750) $display("FAIL alt_bin5 got=%0d exp=750", v);
        else n_pass++;
        read_main(10'd7, v);
        n_checks++;
        if (v !== 32'd250) $display("FAIL alt_bin7 got=%0d exp=250", v);
        else n_pass++;
        read_main(10'd1, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL alt_bin1_cleared got=%0d exp=0", v);
        else n_pass++;
    endtask

    task automatic test_restart_empty();
        logic [31:0] v;
        int nonzero;
        open_window(1);
        close_window(2);
        nonzero = 0;
        for (int i = 0; i < 1024; i++) begin
            read_main(10'(i), v);
            if (v != 0) nonzero++;
        end
        n_checks++;
        if (nonzero != 0) $display("FAIL empty_all_bins nonzero_count=%0d exp=0", nonzero);
        else n_pass++;
    endtask

    task automatic test_window_edges();
        logic [31:0] v;
        // vld during start cycles is ignored, vld with finish is counted,
        // vld in DONE is ignored.
        @(negedge clock); start = 1'b1; vld = 1'b1; data = 10'd9;
        @(negedge clock);
        @(negedge clock); start = 1'b0; finish = 1'b1;
        @(negedge clock); finish = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock); vld = 1'b0;
        read_main(10'd9, v);
        n_checks++;
        if (v !== 32'd1) $display("FAIL edges_bin9 got=%0d exp=1", v);
        else n_pass++;
    endtask

    task automatic test_rst_midcount();
        logic [31:0] v;
        open_window(1);
        repeat (4) send(10'd6);
        @(negedge clock); vld = 1'b0; rst = 1'b1;
        @(negedge clock); rst = 1'b0;
        // Back in IDLE: these samples must not count.
        repeat (3) send(10'd6);
        @(negedge clock); vld = 1'b0;
        repeat (3) @(negedge clock);
        read_main(10'd6, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL rst_mid_bin6 got=%0d exp=0", v);
        else n_pass++;
        read_main(10'd9, v);
        n_checks++;
        if (v !== 32'd0) $display("FAIL rst_mid_bin9 got=%0d exp=0", v);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [3:0] v;
        logic [3:0] exp_bin2;
`ifdef DATA_STATISTICS_SAT_EN
        exp_bin2 = 4'd15;
`else
        exp_bin2 = 4'd1;
`endif
        @(negedge clock); s_start = 1'b1;
        @(negedge clock); s_start = 1'b0;
        repeat (17) begin @(negedge clock); s_vld = 1'b1; s_data = 2'd2; end
        @(negedge clock); s_vld = 1'b0; s_finish = 1'b1;
        repeat (3) @(negedge clock);
        s_finish = 1'b0;
        read_small(2'd2, v);
        n_checks++;
        if (v !== exp_bin2) $display("FAIL overflow_bin2 got=%0d exp=%0d", v, exp_bin2);
        else n_pass++;
        read_small(2'd0, v);
        n_checks++;
        if (v !== 4'd0) $display("FAIL overflow_bin0 got=%0d exp=0", v);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; finish = 1'b0; vld = 1'b0; get_summary = 1'b0;
        data = '0; index = '0;
        s_start = 1'b0; s_finish = 1'b0; s_vld = 1'b0; s_get_summary = 1'b0;
        s_data = '0; s_index = '0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        test_reset();
        test_random();
        test_read_latency();
        test_back_to_back();
        test_alternating();
        test_restart_empty();
        test_window_edges();
        test_rst_midcount();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
